// File: rtl/ticket_pkg.sv
// Shared definitions for the ticket machine: money/stock widths, coin
// denominations and the change dispenser state encoding.
package ticket_pkg;

  localparam int unsigned MONEY_W = 7;  // shared with vending_machine
  localparam int unsigned STOCK_W = 6;
  localparam int unsigned COIN_W  = 4;

  localparam logic [COIN_W-1:0] COIN10 = 4'd10;
  localparam logic [COIN_W-1:0] COIN5  = 4'd5;
  localparam logic [COIN_W-1:0] COIN1  = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_OFFER,
    ST_DONE,
    ST_SHORT
  } disp_state_t;

endpackage

// File: rtl/coin_selector.sv
// Picks the largest coin that fits the remaining change and is in stock.
// Ports:
//   remaining               - change still owed
//   stock10/stock5/stock1   - current stock per denomination
//   value                   - chosen coin value (0 when none)
//   found                   - a payable coin exists
module coin_selector
  import ticket_pkg::*;
(
  input  logic [MONEY_W-1:0] remaining,
  input  logic [STOCK_W-1:0] stock10,
  input  logic [STOCK_W-1:0] stock5,
  input  logic [STOCK_W-1:0] stock1,
  output logic [COIN_W-1:0]  value,
  output logic               found
);

  always_comb begin
    value = '0;
    found = 1'b0;
    if (remaining >= MONEY_W'(COIN10) && stock10 != '0) begin
      value = COIN10;
      found = 1'b1;
    end else if (remaining >= MONEY_W'(COIN5) && stock5 != '0) begin
      value = COIN5;
      found = 1'b1;
    end else if (remaining >= MONEY_W'(COIN1) && stock1 != '0) begin
      value = COIN1;
      found = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change one coin per hopper handshake, largest payable coin first,
// from a finite per-denomination stock; flags a shortage when it runs dry.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   start, changeAmount     - begin a payout of changeAmount (IDLE only)
//   refill                  - reload all stocks (IDLE only)
//   hopperReady             - hopper takes the offered coin this cycle
//   coinValid, coinValue    - coin offer to the hopper
//   busy, done, shortage    - status; done/shortage pulse at payout end
//   remaining, coinsGiven   - change still owed, coins paid this payout
//   stock10/stock5/stock1   - current coin stock
module change_dispenser
  import ticket_pkg::*;
#(
  parameter int unsigned STOCK10 = 8,
  parameter int unsigned STOCK5  = 8,
  parameter int unsigned STOCK1  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MONEY_W-1:0] changeAmount,
  input  logic               refill,
  input  logic               hopperReady,
  output logic               coinValid,
  output logic [COIN_W-1:0]  coinValue,
  output logic               busy,
  output logic               done,
  output logic               shortage,
  output logic [MONEY_W-1:0] remaining,
  output logic [MONEY_W-1:0] coinsGiven,
  output logic [STOCK_W-1:0] stock10,
  output logic [STOCK_W-1:0] stock5,
  output logic [STOCK_W-1:0] stock1
);

  disp_state_t state, state_next;

  logic [COIN_W-1:0] sel_value;
  logic              sel_found;

  coin_selector u_coin_selector (
    .remaining (remaining),
    .stock10   (stock10),
    .stock5    (stock5),
    .stock1    (stock1),
    .value     (sel_value),
    .found     (sel_found)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = (changeAmount == '0) ? ST_DONE : ST_SELECT;
      end
      ST_SELECT: state_next = sel_found ? ST_OFFER : ST_SHORT;
      ST_OFFER: begin
        // Last coin when the offered value exactly covers what is owed
        if (hopperReady)
          state_next = (remaining == MONEY_W'(coinValue)) ? ST_DONE : ST_SELECT;
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_SHORT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    coinValid = (state == ST_OFFER);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE) || (state == ST_SHORT);
    shortage  = (state == ST_SHORT);
  end

  // Payout datapath: owed amount, coin count, offered coin, stocks
  always_ff @(posedge clk) begin
    if (reset) begin
      coinValue  <= '0;
      remaining  <= '0;
      coinsGiven <= '0;
      stock10    <= STOCK_W'(STOCK10);
      stock5     <= STOCK_W'(STOCK5);
      stock1     <= STOCK_W'(STOCK1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (refill) begin
            stock10 <= STOCK_W'(STOCK10);
            stock5  <= STOCK_W'(STOCK5);
            stock1  <= STOCK_W'(STOCK1);
          end
          if (start) begin
            remaining  <= changeAmount;
            coinsGiven <= '0;
          end
        end
        ST_SELECT: begin
          if (sel_found) coinValue <= sel_value;
        end
        ST_OFFER: begin
          if (hopperReady) begin
            remaining  <= remaining - MONEY_W'(coinValue);
            coinsGiven <= coinsGiven + MONEY_W'(1);
            coinValue  <= '0;
            case (coinValue)
              COIN10:  stock10 <= stock10 - STOCK_W'(1);
              COIN5:   stock5  <= stock5 - STOCK_W'(1);
              COIN1:   stock1  <= stock1 - STOCK_W'(1);
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser with a greedy-payout
// reference model, plus directed timing, backpressure, shortage and reset cases.
module tb_change_dispenser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, refill, hopperReady;
  logic [6:0] changeAmount;
  logic       coinValid, busy, done, shortage;
  logic [3:0] coinValue;
  logic [6:0] remaining, coinsGiven;
  logic [5:0] stock10, stock5, stock1;

  // Second instance with a tiny stock for the shortage case
  logic       s_start, s_refill, s_hready;
  logic [6:0] s_amt;
  logic       s_valid, s_busy, s_done, s_short;
  logic [3:0] s_value;
  logic [6:0] s_rem, s_given;
  logic [5:0] s_st10, s_st5, s_st1;

  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start), .changeAmount(changeAmount),
    .refill(refill), .hopperReady(hopperReady), .coinValid(coinValid),
    .coinValue(coinValue), .busy(busy), .done(done), .shortage(shortage),
    .remaining(remaining), .coinsGiven(coinsGiven),
    .stock10(stock10), .stock5(stock5), .stock1(stock1)
  );

  change_dispenser #(.STOCK10(1), .STOCK5(0), .STOCK1(2)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .changeAmount(s_amt),
    .refill(s_refill), .hopperReady(s_hready), .coinValid(s_valid),
    .coinValue(s_value), .busy(s_busy), .done(s_done), .shortage(s_short),
    .remaining(s_rem), .coinsGiven(s_given),
    .stock10(s_st10), .stock5(s_st5), .stock1(s_st1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int short_f;
    int rem;
    int given;
    int s10;
    int s5;
    int s1;
  } end_t;

  int   exp_coins[$];
  end_t exp_end[$];
  int   m10, m5, m1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_refill();
    m10 = 8; m5 = 8; m1 = 16;
  endtask

  // Greedy payout from the stocks held by the model
  task automatic model_payout(input int amt);
    int   rem, n, d;
    end_t e;
    rem = amt;
    n   = 0;
    while (1) begin
      if (rem >= 10 && m10 > 0)     begin d = 10; m10--; end
      else if (rem >= 5 && m5 > 0)  begin d = 5;  m5--;  end
      else if (rem >= 1 && m1 > 0)  begin d = 1;  m1--;  end
      else break;
      rem -= d;
      n++;
      exp_coins.push_back(d);
    end
    e.short_f = (rem != 0) ? 1 : 0;
    e.rem = rem; e.given = n; e.s10 = m10; e.s5 = m5; e.s1 = m1;
    exp_end.push_back(e);
  endtask

  // Drives one start cycle; returns during cycle 1 after acceptance
  task automatic issue_start(input int amt, input bit with_refill);
    if (with_refill) begin
      model_refill();
      refill = 1'b1;
    end
    model_payout(amt);
    start = 1'b1;
    changeAmount = 7'(amt);
    @(posedge clk); #1;
    start  = 1'b0;
    refill = 1'b0;
  endtask

  // Runs the hopper until done, then steps back into IDLE
  task automatic wait_done(input bit always_ready);
    int n;
    n = 0;
    while (!done && n < 1000) begin
      hopperReady = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
    hopperReady = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_refill();
    refill = 1'b1;
    @(posedge clk); #1;
    refill = 1'b0;
    model_refill();
    check("refill_s10", stock10, 8);
    check("refill_s5", stock5, 8);
    check("refill_s1", stock1, 16);
  endtask

  // Monitor: checks every accepted coin and every payout end against the queues
  bit held_v = 1'b0;
  int held_val = 0;
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (coinValid) begin
        if (held_v) check("coin_hold", coinValue, held_val);
        if (hopperReady) begin
          if (exp_coins.size() == 0) check("coin_extra", coinValue, 0);
          else check("coin_value", coinValue, exp_coins.pop_front());
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_val = coinValue;
        end
      end else begin
        held_v = 1'b0;
        check("idle_value", coinValue, 0);
      end
      if (done) begin
        if (exp_end.size() == 0) begin
          check("done_extra", 1, 0);
        end else begin
          end_t e;
          e = exp_end.pop_front();
          check("coins_left", exp_coins.size(), 0);
          check("end_shortage", shortage, e.short_f);
          check("end_remaining", remaining, e.rem);
          check("end_given", coinsGiven, e.given);
          check("end_s10", stock10, e.s10);
          check("end_s5", stock5, e.s5);
          check("end_s1", stock1, e.s1);
        end
      end
    end
  end

  initial begin
    int got[$];
    int expv[3];
    int n;

    reset = 1'b1; start = 1'b0; refill = 1'b0; hopperReady = 1'b0;
    changeAmount = '0;
    s_start = 1'b0; s_refill = 1'b0; s_hready = 1'b1; s_amt = '0;
    model_refill();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", coinValid, 0);
    check("rst_value", coinValue, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", shortage, 0);
    check("rst_rem", remaining, 0);
    check("rst_given", coinsGiven, 0);
    check("rst_s10", stock10, 8);
    check("rst_s5", stock5, 8);
    check("rst_s1", stock1, 16);
    reset = 1'b0;

    // Change 16 with the hopper always ready: coins in cycles 2,4,6, done in 7
    hopperReady = 1'b1;
    issue_start(16, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("c16_valid_cyc%0d", k), coinValid, (k == 2 || k == 4 || k == 6) ? 1 : 0);
      check($sformatf("c16_done_cyc%0d", k), done, (k == 7) ? 1 : 0);
      if (k < 7) begin @(posedge clk); #1; end
    end
    hopperReady = 1'b0;
    @(posedge clk); #1;
    check("c16_busy_after", busy, 0);

    // Change 0: immediate done, no coin
    issue_start(0, 1'b0);
    check("c0_done", done, 1);
    check("c0_valid", coinValid, 0);
    check("c0_short", shortage, 0);
    check("c0_rem", remaining, 0);
    @(posedge clk); #1;

    // Change 10 held off for three OFFER cycles
    hopperReady = 1'b0;
    issue_start(10, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_cyc%0d", k), coinValid, 1);
      check($sformatf("bp_value_cyc%0d", k), coinValue, 10);
      check($sformatf("bp_rem_cyc%0d", k), remaining, 10);
    end
    @(posedge clk); #1;
    hopperReady = 1'b1;
    check("bp_valid_cyc5", coinValid, 1);
    @(posedge clk); #1;
    hopperReady = 1'b0;
    check("bp_done", done, 1);
    check("bp_rem_end", remaining, 0);
    @(posedge clk); #1;

    // start pulsed during OFFER is ignored
    issue_start(7, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    changeAmount = 7'd99;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_rem", remaining, 7);
    wait_done(1'b1);
    do_refill();

    // Randomized payouts, with refills mixed in so stocks drain and recover
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) do_refill();
      issue_start(int'($urandom_range(0, 127)), ($urandom_range(0, 4) == 0));
      wait_done(1'b0);
    end

    // Reset in the middle of OFFER abandons the payout
    hopperReady = 1'b0;
    issue_start(50, 1'b1);
    @(posedge clk); #1;
    check("mid_valid_before", coinValid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_coins.delete();
    exp_end.delete();
    model_refill();
    check("mid_valid", coinValid, 0);
    check("mid_busy", busy, 0);
    check("mid_rem", remaining, 0);
    check("mid_given", coinsGiven, 0);
    check("mid_s10", stock10, 8);
    check("mid_s5", stock5, 8);
    check("mid_s1", stock1, 16);
    reset = 1'b0;
    @(posedge clk); #1;

    // Small-stock instance: change 15 pays 10,1,1 then reports shortage
    s_amt = 7'd15;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n = 0;
    while (!s_done && n < 100) begin
      if (s_valid) got.push_back(int'(s_value));
      @(posedge clk); #1;
      n++;
    end
    expv[0] = 10; expv[1] = 1; expv[2] = 1;
    check("sh_ncoins", got.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("sh_coin%0d", i), (i < got.size()) ? got[i] : -1, expv[i]);
    check("sh_done", s_done, 1);
    check("sh_short", s_short, 1);
    check("sh_rem", s_rem, 3);
    check("sh_given", s_given, 3);
    check("sh_s10", s_st10, 0);
    check("sh_s5", s_st5, 0);
    check("sh_s1", s_st1, 0);
    @(posedge clk); #1;

    check("sb_coins_empty", exp_coins.size(), 0);
    check("sb_end_empty", exp_end.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
